ser_interp_filter: RTL and testbench

SER_INTERP_FILTER -- requirements
Module: ser_interp_filter

---
 rtl/ser_interp_pkg.sv | 53 +++++
 rtl/ser_round_sat.sv | 43 ++++
 rtl/ser_interp_filter.sv | 114 +++++++++++
 tb/tb_ser_interp_filter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_interp_pkg.sv
// ser_interp_pkg: shared widths, FSM state encoding and the symmetric
// 30-tap prototype coefficient table for the x2 serial interpolator.
package ser_interp_pkg;

  localparam int IDATA_W_D = 16;
  localparam int COEFF_W_D = 16;
  localparam int OUT_W_D   = 16;
  localparam int FIR_TAP_D = 30;
  localparam int ACC_W_D   = 36;
  localparam int SHIFT_D   = 15;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MAC0 = 3'd1;
  localparam logic [2:0] ST_OUT0 = 3'd2;
  localparam logic [2:0] ST_MAC1 = 3'd3;
  localparam logic [2:0] ST_OUT1 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MAC0 = ST_MAC0,
    S_OUT0 = ST_OUT0,
    S_MAC1 = ST_MAC1,
    S_OUT1 = ST_OUT1
  } state_e;

  // h[k] = h[29-k]; only the first half is stored
  function automatic logic signed [15:0] ser_coeff(
    input logic [4:0] i
  );
    logic [3:0] j;
    logic signed [15:0] c;
    j = (i < 5'd15) ? i[3:0] : 4'(5'd29 - i);
    case (j)
      4'd0:    c = 16'sd169;
      4'd1:    c = 16'sd468;
      4'd2:    c = 16'sd1050;
      4'd3:    c = 16'sd2015;
      4'd4:    c = 16'sd3467;
      4'd5:    c = 16'sd5484;
      4'd6:    c = 16'sd8098;
      4'd7:    c = 16'sd11274;
      4'd8:    c = 16'sd14904;
      4'd9:    c = 16'sd18800;
      4'd10:   c = 16'sd22710;
      4'd11:   c = 16'sd26343;
      4'd12:   c = 16'sd29399;
      4'd13:   c = 16'sd31608;
      default: c = 16'sd32767;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ser_round_sat.sv
// ser_round_sat: round-half-up right shift of the accumulator, then
// wrap (default) or saturate (SER_INTERP_SAT_EN) to OUT_WIDTH.
// Ports: acc (signed accumulator in), dout (signed rounded sample out).
module ser_round_sat #(
  parameter int ACC_WIDTH = 36,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] dout
);

  localparam int QW = ACC_WIDTH - SHIFT + 1;
  localparam int HW = QW - OUT_WIDTH + 1;

  localparam logic signed [ACC_WIDTH:0] HALF =
    {{(ACC_WIDTH-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum;
  logic signed [QW-1:0]      q;
  logic [HW-1:0]             hi;
  logic                      unused_bits;

  // one guard bit so adding the half LSB cannot overflow
  assign sum = {acc[ACC_WIDTH-1], acc} + HALF;
  assign q   = sum[ACC_WIDTH:SHIFT];
  assign hi  = q[QW-1:OUT_WIDTH-1];

`ifdef SER_INTERP_SAT_EN
  always_comb begin
    dout = q[OUT_WIDTH-1:0];
    if (!((&hi) || (~|hi))) begin
      dout = q[QW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
  assign unused_bits = ^sum[SHIFT-1:0];
`else
  assign dout = q[OUT_WIDTH-1:0];
  assign unused_bits = ^{sum[SHIFT-1:0], hi};
`endif

endmodule

// File: rtl/ser_interp_filter.sv
// ser_interp_filter: serial single-MAC x2 polyphase interpolating FIR.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data (sample in),
// out_valid/out_ready/out_data (two outputs per input, phase 0 first).
// Optional: SER_INTERP_SAT_EN selects saturating output (else wrap).
module ser_interp_filter
  import ser_interp_pkg::*;
#(
  parameter int IDATA_WIDTH = IDATA_W_D,
  parameter int COEFF_WIDTH = COEFF_W_D,
  parameter int OUT_WIDTH   = OUT_W_D,
  parameter int FIR_TAP     = FIR_TAP_D,
  parameter int ACC_WIDTH   = ACC_W_D,
  parameter int SHIFT       = SHIFT_D
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IDATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam int NPH = FIR_TAP / 2;
  localparam int CW  = $clog2(NPH);
  localparam int PW  = IDATA_WIDTH + COEFF_WIDTH;

  state_e                       state;
  logic [CW-1:0]                cnt;
  logic signed [IDATA_WIDTH-1:0] x [NPH];
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_nxt;
  logic signed [COEFF_WIDTH-1:0] h_sel;
  logic signed [IDATA_WIDTH-1:0] x_sel;
  logic signed [PW-1:0]         prod;
  logic signed [OUT_WIDTH-1:0]  rnd;
  logic [CW:0]                  idx;
  logic                         phase;
  logic                         last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT0) ||
                     (state == S_OUT1);

  assign phase = (state == S_MAC1);
  assign last  = (cnt == CW'(NPH - 1));

  // tap 2k+p of the prototype pairs with x[k]
  assign idx   = {cnt, phase};
  assign h_sel = COEFF_WIDTH'(ser_coeff(idx));
  assign x_sel = x[cnt];

  assign prod    = PW'(h_sel) * PW'(x_sel);
  assign acc_nxt = acc + ACC_WIDTH'(prod);

  // the last MAC result is rounded straight into out_data
  ser_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_round_sat (
    .acc  (acc_nxt),
    .dout (rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int k = 0; k < NPH; k++) begin
        x[k] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = NPH - 1; k > 0; k--) begin
              x[k] <= x[k-1];
            end
            x[0]  <= in_data;
            acc   <= '0;
            cnt   <= '0;
            state <= S_MAC0;
          end
        end
        S_MAC0, S_MAC1: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            out_data <= rnd;
            state    <= (state == S_MAC0) ? S_OUT0 : S_OUT1;
          end
        end
        S_OUT0: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_MAC1;
          end
        end
        S_OUT1: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_interp_filter.sv
// tb_ser_interp_filter: directed + randomized bench for the serial
// x2 interpolator, checked against a sum-of-products reference model.
module tb_ser_interp_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic signed [15:0] out_data;

  always #5 clk = ~clk;

  ser_interp_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int h_half [15] = '{169, 468, 1050, 2015, 3467, 5484, 8098, 11274,
                      14904, 18800, 22710, 26343, 29399, 31608, 32767};
  int hist [15];
  int exp_q [$];
  int out_log [$];
  int acc_cyc [$];

  function automatic int hc(int n);
    return (n < 15) ? h_half[n] : h_half[29 - n];
  endfunction

  function automatic int reduce(longint s);
    longint r;
    r = (s + 16384) >>> 15;
`ifdef SER_INTERP_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = r & 64'hFFFF;
    if (r >= 32768) r = r - 65536;
`endif
    return int'(r);
  endfunction

  function automatic int phase_out(int p);
    longint s = 0;
    for (int k = 0; k < 15; k++) begin
      s += longint'(hc(2 * k + p)) * longint'(hist[k]);
    end
    return reduce(s);
  endfunction

  task automatic model_accept(int d);
    for (int k = 14; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    exp_q.push_back(phase_out(0));
    exp_q.push_back(phase_out(1));
  endtask

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int trig = -1000;
  logic prev_v = 1'b0;
  logic held = 1'b0;
  logic signed [15:0] held_d = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      for (int k = 0; k < 15; k++) hist[k] = 0;
      prev_v = 1'b0;
      held = 1'b0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(exp_q.size() == 0));
      if (held) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_data", out_data, held_d);
      end
      if (out_valid && !prev_v) check("latency", cyc, trig + 16);
      if (in_valid && in_ready) begin
        model_accept(int'(in_data));
        trig = cyc;
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_data, 99999);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        out_log.push_back(int'(out_data));
        trig = cyc;
      end
      held = out_valid && !out_ready;
      held_d = out_data;
      prev_v = out_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send(int d);
    bit ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 16'(d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) return;
    end
    check("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (in_ready) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic run_impulse(string tag);
    int n1, n2;
    out_log.delete();
    send(16384);
    wait_valid(n1);
    check({tag, "_lat16"}, n1, 16);
    wait_idle(n2);
    check({tag, "_ready33"}, n1 + n2, 33);
    for (int i = 0; i < 15; i++) begin
      send(0);
      wait_idle(n2);
    end
    check({tag, "_count"}, out_log.size(), 32);
    if (out_log.size() == 32) begin
      check({tag, "_y0"}, out_log[0], 85);
      check({tag, "_y1"}, out_log[1], 234);
      check({tag, "_y2"}, out_log[2], 525);
      check({tag, "_y3"}, out_log[3], 1008);
      check({tag, "_y29"}, out_log[29], 85);
      check({tag, "_y30"}, out_log[30], 0);
      check({tag, "_y31"}, out_log[31], 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    #1;
    check("por_out_valid", longint'(out_valid), 0);
    check("por_out_data", out_data, 0);
    #20 rst_n = 1'b1;
    out_ready = 1'b1;

    // impulse response
    run_impulse("imp");

    // constant full-scale input
    do_reset();
    out_log.delete();
    for (int i = 0; i < 15; i++) begin
      send(16384);
      wait_idle(n);
    end
    check("const_count", out_log.size(), 30);
    if (out_log.size() == 30) begin
`ifdef SER_INTERP_SAT_EN
      check("const_p0", out_log[28], 32767);
      check("const_p1", out_log[29], 32767);
`else
      check("const_p0", out_log[28], -26794);
      check("const_p1", out_log[29], -26794);
`endif
    end

    // downstream stall during phase 0
    do_reset();
    out_log.delete();
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(-12000);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", longint'(in_ready), 0);
      check("stall_no_out", out_log.size(), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle(n);
    check("stall_count", out_log.size(), 2);

    // reset in the middle of phase-1 accumulation
    do_reset();
    out_log.delete();
    send(12345);
    for (int i = 0; i < 200 && out_log.size() < 1; i++) @(negedge clk);
    check("mac1_phase0_seen", out_log.size(), 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_valid", longint'(out_valid), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_impulse("rimp");

    // in_valid held high: one accept per 33 cycles
    do_reset();
    acc_cyc.delete();
    @(posedge clk);
    #1 in_valid = 1'b1;
    for (int i = 0; i < 33 * 8; i++) begin
      in_data = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle(n);
    check("held_accepts", acc_cyc.size(), 8);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check("held_period", acc_cyc[i] - acc_cyc[i-1], 33);
    end

    // random traffic and backpressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 3) == 0);
      in_data = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle(n);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
